// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
// The PARITY state is always declared; it is only reachable when the
// controller is built with UART_TX_PARITY_EN defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Level of the serial line between frames, and the level of the start bit.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage : uart_pkg

// File: rtl/baud_tick_gen.sv
// Baud tick generator: counts clock cycles and pulses tick for one cycle
// when the count reaches CLKS_PER_BIT-1, then wraps to 0. restart clears
// the count synchronously and masks tick in the same cycle, so the first
// tick after a restart lands exactly CLKS_PER_BIT cycles later.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 180
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = !restart && (count_q == LAST);

    // Next count: wrap on tick, clear on restart, otherwise advance.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (restart || tick) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : baud_tick_gen

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, DATA_BITS data bits LSB first,
// optional even parity bit, one stop bit. Every bit lasts CLKS_PER_BIT cycles.
// Build option: define UART_TX_PARITY_EN to insert the even parity bit.
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid and
// tx_ready are both high. tx_ready is high only in IDLE; tx_valid while busy
// is ignored. tx_data is sampled only at acceptance and may change afterwards.
// The source holds tx_valid until it sees tx_ready.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 180,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output tx_state_t            dbg_state_o
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic baud_restart;
    logic baud_tick;

    // The baud counter sits cleared for the whole of IDLE, which also makes
    // the accept edge restart it so the start bit is a full bit period.
    assign baud_restart = (state_q == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(baud_restart),
        .tick   (baud_tick)
    );

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign tx          = tx_q;
    assign dbg_state_o = state_q;

    // Next-state and next line level; tx is registered so it changes on the
    // same edge as the state it belongs to.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = LINE_IDLE;
                if (tx_valid) begin
                    shift_d = tx_data;
                    idx_d   = '0;
                    tx_d    = START_BIT;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = LINE_IDLE;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    tx_d    = LINE_IDLE;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx_d = LINE_IDLE;
                if (baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = LINE_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    // State, line and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= LINE_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl at CLKS_PER_BIT=4, DATA_BITS=8. Follows
// UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DB + 3;
`else
    localparam int NB = DB + 2;
`endif
    localparam int FRAME = NB * CPB;

    // ---------------- clock / reset ----------------
    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    tx_state_t     dbg_state;
    int            cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Line levels of one frame, index = bit slot from the start bit onward.
    function automatic logic [NB-1:0] frame_bits(input logic [DB-1:0] d);
        logic [NB-1:0] b;
        b    = '1;
        b[0] = 1'b0;
        for (int k = 0; k < DB; k++) b[k+1] = d[k];
`ifdef UART_TX_PARITY_EN
        b[DB+1] = ^d;
`endif
        b[NB-1] = 1'b1;
        return b;
    endfunction

    function automatic tx_state_t slot_state(input int k);
        if (k == 0) return START;
        if (k <= DB) return DATA;
        if (k == NB - 1) return STOP;
        return PARITY;
    endfunction

    logic [NB-1:0] exp_q[$];
    int            m_pos = 0;

    // A frame is accepted whenever the model has nothing in flight and the
    // source offers a byte; it lasts FRAME edges, then one idle cycle follows.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_pos <= 0;
        end else if (exp_q.size() != 0) begin
            if (m_pos == FRAME - 1) begin
                void'(exp_q.pop_front());
                m_pos <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end else if (tx_valid) begin
            exp_q.push_back(frame_bits(tx_data));
            m_pos <= 0;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin : cmp
        logic [NB-1:0] fb;
        logic          e_tx;
        logic          e_busy;
        tx_state_t     e_st;
        if (exp_q.size() != 0) begin
            fb     = exp_q[0];
            e_tx   = fb[m_pos / CPB];
            e_busy = 1'b1;
            e_st   = slot_state(m_pos / CPB);
        end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
            e_st   = IDLE;
        end
        check("cyc_tx", 32'(tx), 32'(e_tx));
        check("cyc_busy", 32'(busy), 32'(e_busy));
        check("cyc_tx_ready", 32'(tx_ready), 32'(!e_busy));
        check("cyc_state", 32'(dbg_state), 32'(e_st));
    end

    // ---------------- driver tasks ----------------
    // Offers one byte (DUT must be idle), drops valid and scrambles data after
    // acceptance, optionally pulses valid with 0x3C at negedge pulse_at, and
    // samples tx mid-slot for each bit and counts busy cycles.
    task automatic send_capture(input logic [DB-1:0] d, input int pulse_at,
                                output logic [NB-1:0] bits, output int busy_cnt);
        bits     = '0;
        busy_cnt = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= FRAME + 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                tx_valid = 1'b0;
                tx_data  = ~d;
            end
            if (i == pulse_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end
            if (i == pulse_at + 1) tx_valid = 1'b0;
            if (busy) busy_cnt++;
            if (i <= FRAME && ((i - 1) % CPB) == 1) bits[(i - 1) / CPB] = tx;
        end
    endtask

    // ---------------- hand-computed expectations ----------------
`ifdef UART_TX_PARITY_EN
    localparam logic [NB-1:0] EXP_A5 = 11'h54A;
    localparam logic [NB-1:0] EXP_5A = 11'h4B4;
    localparam logic [NB-1:0] EXP_81 = 11'h502;
    localparam logic [NB-1:0] EXP_07 = 11'h60E;
    localparam logic [NB-1:0] EXP_03 = 11'h406;
    localparam int BUSY_LIT = 44;
    localparam int B2B_LIT  = 45;
`else
    localparam logic [NB-1:0] EXP_A5 = 10'h34A;
    localparam logic [NB-1:0] EXP_5A = 10'h2B4;
    localparam logic [NB-1:0] EXP_81 = 10'h302;
    localparam logic [NB-1:0] EXP_07 = 10'h20E;
    localparam logic [NB-1:0] EXP_03 = 10'h206;
    localparam int BUSY_LIT = 40;
    localparam int B2B_LIT  = 41;
`endif

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NB-1:0] bits;
        int            bc;
        int            cnt;
        int            t1;
        int            t2;
        int            gap;
        logic          pb;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        // Line stays idle with no source activity
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx === 1'b1) cnt++;
        end
        check("idle_tx_high_50", 32'(cnt), 32'd50);

        // Single frame 0xA5
        send_capture(8'hA5, 0, bits, bc);
        check("a5_bits", 32'(bits), 32'(EXP_A5));
        check("a5_busy_cycles", 32'(bc), 32'(BUSY_LIT));

        // Valid pulse during DATA is ignored
        send_capture(8'h5A, 3 * CPB + 2, bits, bc);
        check("5a_bits", 32'(bits), 32'(EXP_5A));
        check("5a_busy_cycles", 32'(bc), 32'(BUSY_LIT));
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt++;
        end
        check("no_extra_frame", 32'(cnt), 32'd0);

        // Back-to-back: valid held across two frames
        t1 = -1;
        t2 = -1;
        gap = 0;
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        for (int i = 0; i < 10 && t1 < 0; i++) begin
            @(negedge clk);
            if (busy) t1 = cyc;
        end
        tx_data = 8'hFF;
        pb = 1'b1;
        for (int i = 0; i < FRAME + 20 && t2 < 0; i++) begin
            @(negedge clk);
            if (!busy) gap++;
            if (!pb && busy) t2 = cyc;
            pb = busy;
        end
        tx_valid = 1'b0;
        check("b2b_first_accept", 32'(t1 >= 0), 32'd1);
        check("b2b_second_accept", 32'(t2 >= 0), 32'd1);
        check("b2b_accept_spacing", 32'(t2 - t1), 32'(B2B_LIT));
        check("b2b_idle_cycles", 32'(gap), 32'd1);
        repeat (FRAME + 5) @(negedge clk);

        // Mid-frame reset during bit 3 of 0x55
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 4 * CPB + 2; i++) begin
            @(negedge clk);
            if (i == 1) tx_valid = 1'b0;
        end
        check("mid_busy_before", 32'(busy), 32'd1);
        check("mid_tx_before", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_tx_async", 32'(tx), 32'd1);
        check("mid_busy_async", 32'(busy), 32'd0);
        check("mid_ready_async", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_capture(8'h81, 0, bits, bc);
        check("81_bits", 32'(bits), 32'(EXP_81));
        check("81_busy_cycles", 32'(bc), 32'(BUSY_LIT));

        // Parity-sensitive bytes (odd and even population)
        send_capture(8'h07, 0, bits, bc);
        check("07_bits", 32'(bits), 32'(EXP_07));
        check("07_busy_cycles", 32'(bc), 32'(BUSY_LIT));
        send_capture(8'h03, 0, bits, bc);
        check("03_bits", 32'(bits), 32'(EXP_03));
        check("03_busy_cycles", 32'(bc), 32'(BUSY_LIT));

        repeat (5) @(negedge clk);
        check("model_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_tx_ctrl

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Serial transmit controller for the communication link. Accepts parallel bytes over a valid/ready handshake and sequences them onto a single serial line as start bit, LSB-first data, optional even parity and stop bit. Bit timing comes from an internal baud tick generator that is restarted at each frame so every bit lasts exactly CLKS_PER_BIT cycles. It sits between the byte source (framer/FIFO) and the TX pin.

## Interface
- CLKS_PER_BIT, 180, clock cycles per serial bit; legal range is 2 or more.
- DATA_BITS, 8, payload bits per frame.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on acceptance.
- tx_valid  input  1  the source has a byte on tx_data.
- tx_ready  output  1  the controller can accept a byte; high only in IDLE.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  a frame is in progress; high in every state except IDLE.

## Operation
- States: IDLE, START, DATA, PARITY (present only when the parity macro is defined), STOP.
- **Accept:** when tx_valid and tx_ready are both high on a clk edge:
  - latch tx_data into a shift register;
  - clear the bit index;
  - restart the baud generator;
  - go to START with tx set to 0.
- **START:** hold tx=0 for CLKS_PER_BIT cycles. On tick, go to DATA and drive shift[0].
- **DATA:** on each tick, shift right and increment the bit index. After DATA_BITS bits, go to PARITY if present, otherwise STOP.
- **PARITY:** drive the XOR of the latched byte (even parity) for one bit period, then go to STOP.
- **STOP:** drive tx=1 for one bit period. On tick, go to IDLE.
- **Handshake:**
  - tx_valid while busy is ignored and does not stall anything.
  - tx_data may change freely after acceptance.
  - The source must hold tx_valid until it sees tx_ready.
- The bit index is $clog2(DATA_BITS+1) bits wide. The baud count is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 on tick.

## Timing
- **Reset values:** tx=1, tx_ready=1, busy=0, state=IDLE, baud count=0.
- **Mid-frame reset:** tx returns to 1 immediately. The frame is abandoned and is not resumed.
- **Latency:** tx falls on the same edge that accepts the byte. busy rises on that edge, and tx_ready falls on that edge.
- **Bit periods:** every bit, including the first, is exactly CLKS_PER_BIT cycles.
- **Frame length** (accept edge to return to IDLE): (DATA_BITS+2)*CLKS_PER_BIT cycles, or (DATA_BITS+3)*CLKS_PER_BIT with parity.
- **Back-to-back frames:**
  - After STOP, the controller spends exactly one cycle in IDLE, with tx=1 and tx_ready=1.
  - If tx_valid is high in that cycle, the next frame starts on the following edge.
  - So the stop bit is CLKS_PER_BIT+1 cycles between consecutive frames.
- **Tick in IDLE:** the baud generator is held cleared in IDLE, so it never produces a tick there.

## Configuration
- UART_TX_PARITY_EN defined:
  - the PARITY state exists;
  - an even parity bit follows the data bits;
  - frame length is (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined:
  - no PARITY state and no parity logic;
  - DATA goes directly to STOP;
  - frame length is (DATA_BITS+2)*CLKS_PER_BIT.

## Structure
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the line-level constants LINE_IDLE=1 and START_BIT=0.
- One sub-module, baud_tick_gen:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst_n, restart;
  - output tick, a one-cycle pulse when count==CLKS_PER_BIT-1;
  - restart clears the count synchronously and suppresses tick in that cycle.

## Test plan
- **Reset:** assert rst_n=0 mid-operation, then release → tx=1, tx_ready=1, busy=0, and tx stays 1 for 50 cycles with tx_valid=0.
- **Single frame:** CLKS_PER_BIT=4, no parity, send 0xA5 → tx levels in 4-cycle runs are 0,1,0,1,0,0,1,0,1,1; busy is high for 40 cycles.
- **Back-to-back:** tx_valid held high with 0x00 then 0xFF → one IDLE cycle between frames; second frame starts 41 cycles after the first accept.
- **Valid while busy:** pulse tx_valid with 0x3C during DATA → ignored; no extra frame is sent and the current frame is unaltered.
- **Mid-frame reset:** assert rst_n low at bit 3 of 0x55 → tx goes to 1 at once; after release, a new 0x81 frame is transmitted cleanly.
- **Parity:** with UART_TX_PARITY_EN, send 0x07 → parity bit is 1, then stop; send 0x03 → parity bit is 0; frame is 44 cycles at CLKS_PER_BIT=4.
